// File: rtl/paging_unit.sv
// Two-level 4 KiB paging: fully-associative TLB in front of a PDE/PTE walker
// that sets accessed/dirty bits and reports faults with an error code and CR2.
module paging_unit #(
    parameter int TLB_ENTRIES     = 8,
    parameter int TLB_INDEX_WIDTH = $clog2(TLB_ENTRIES)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        paging_enable,
    input  logic [19:0] page_directory_base,
    input  logic        tlb_flush,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic [31:0] linear_address,
    input  logic        read_write_n,
    input  logic        user_mode,
    output logic        response_valid,
    output logic [31:0] physical_address,
    output logic        page_fault,
    output logic [2:0]  fault_error_code,
    output logic [31:0] fault_linear_address,
    output logic        mem_read_valid,
    input  logic        mem_read_ready,
    output logic [31:0] mem_read_address,
    input  logic        mem_read_data_valid,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_valid,
    input  logic        mem_write_ready,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, PDE_READ, PDE_WAIT, PDE_UPDATE,
        PTE_READ, PTE_WAIT, PTE_UPDATE, RESPOND
    } state_t;

    state_t      state_q;
    logic        request_ready_q, response_valid_q, page_fault_q;
    logic [31:0] physical_address_q, fault_linear_address_q;
    logic [2:0]  fault_error_code_q;
    logic        mem_read_valid_q, mem_write_valid_q;
    logic [31:0] mem_read_address_q, mem_write_address_q, mem_write_data_q;

    logic [31:0] lin_q;
    logic        read_q, user_q, suppress_q;
    logic [19:0] pde_base_q, pte_ppn_q;
    logic        pde_u_q, pde_rw_q, pte_u_q, pte_rw_q, pte_d_q;

    logic [TLB_ENTRIES-1:0]     tlb_valid_q, tlb_user_q, tlb_wr_q, tlb_dirty_q;
    logic [19:0]                tlb_vpn_q [TLB_ENTRIES];
    logic [19:0]                tlb_ppn_q [TLB_ENTRIES];
    logic [TLB_INDEX_WIDTH-1:0] repl_q;

    function automatic logic perm_ok(input logic um, input logic wr,
                                     input logic u, input logic w);
        return !um || (u && (!wr || w));
    endfunction

    logic                       hit_any;
    logic [TLB_INDEX_WIDTH-1:0] hit_idx;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_valid_q[i] && tlb_vpn_q[i] == lin_q[31:12]) begin
                hit_any = 1'b1;
                hit_idx = TLB_INDEX_WIDTH'(i);
            end
        end
    end

    logic [31:0] pte_new;
    logic        pte_perm, hit_perm;
    logic        fault_now, fault_p, done_now;
    logic [31:0] done_pa;
    logic        fill_en, fill_u, fill_w, fill_d;
    logic [19:0] fill_ppn;

    always_comb begin
        pte_new  = mem_read_data | 32'h20 | (read_q ? 32'h0 : 32'h40);
        pte_perm = perm_ok(user_q, !read_q, pde_u_q & mem_read_data[2],
                           pde_rw_q & mem_read_data[1]);
        hit_perm = perm_ok(user_q, !read_q, tlb_user_q[hit_idx], tlb_wr_q[hit_idx]);
        fault_now = 1'b0;
        fault_p   = 1'b0;
        done_now  = 1'b0;
        done_pa   = {tlb_ppn_q[hit_idx], lin_q[11:0]};
        fill_en   = 1'b0;
        fill_ppn  = mem_read_data[31:12];
        fill_u    = pde_u_q & mem_read_data[2];
        fill_w    = pde_rw_q & mem_read_data[1];
        fill_d    = mem_read_data[6];
        case (state_q)
            LOOKUP: begin
                // a write to a clean entry falls through to the walk so D gets set
                if (hit_any && !hit_perm) begin
                    fault_now = 1'b1;
                    fault_p   = 1'b1;
                end else if (hit_any && (read_q || tlb_dirty_q[hit_idx])) begin
                    done_now = 1'b1;
                end
            end
            PDE_WAIT: fault_now = mem_read_data_valid && !mem_read_data[0];
            PTE_WAIT: begin
                if (mem_read_data_valid) begin
                    if (!mem_read_data[0] || !pte_perm) begin
                        fault_now = 1'b1;
                        fault_p   = mem_read_data[0];
                    end else if (pte_new == mem_read_data) begin
                        done_now = 1'b1;
                        fill_en  = 1'b1;
                        done_pa  = {mem_read_data[31:12], lin_q[11:0]};
                    end
                end
            end
            PTE_UPDATE: begin
                if (mem_write_ready) begin
                    done_now = 1'b1;
                    fill_en  = 1'b1;
                    done_pa  = {pte_ppn_q, lin_q[11:0]};
                    fill_ppn = pte_ppn_q;
                    fill_u   = pde_u_q & pte_u_q;
                    fill_w   = pde_rw_q & pte_rw_q;
                    fill_d   = pte_d_q;
                end
            end
            default: ;
        endcase
        fill_en = fill_en && !suppress_q && !tlb_flush;
    end

    // Fill reuses a matching entry (dirty upgrade) so the VPN never appears twice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tlb_valid_q <= '0;
            tlb_user_q  <= '0;
            tlb_wr_q    <= '0;
            tlb_dirty_q <= '0;
            repl_q      <= '0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb_vpn_q[i] <= '0;
                tlb_ppn_q[i] <= '0;
            end
        end else if (tlb_flush) begin
            tlb_valid_q <= '0;
        end else if (fill_en) begin
            if (hit_any) begin
                tlb_ppn_q[hit_idx]   <= fill_ppn;
                tlb_user_q[hit_idx]  <= fill_u;
                tlb_wr_q[hit_idx]    <= fill_w;
                tlb_dirty_q[hit_idx] <= fill_d;
            end else begin
                tlb_valid_q[repl_q] <= 1'b1;
                tlb_vpn_q[repl_q]   <= lin_q[31:12];
                tlb_ppn_q[repl_q]   <= fill_ppn;
                tlb_user_q[repl_q]  <= fill_u;
                tlb_wr_q[repl_q]    <= fill_w;
                tlb_dirty_q[repl_q] <= fill_d;
                repl_q              <= repl_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q                <= IDLE;
            request_ready_q        <= 1'b0;
            response_valid_q       <= 1'b0;
            page_fault_q           <= 1'b0;
            physical_address_q     <= '0;
            fault_error_code_q     <= '0;
            fault_linear_address_q <= '0;
            mem_read_valid_q       <= 1'b0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= 1'b0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            lin_q                  <= '0;
            read_q                 <= 1'b0;
            user_q                 <= 1'b0;
            suppress_q             <= 1'b0;
            pde_base_q             <= '0;
            pde_u_q                <= 1'b0;
            pde_rw_q               <= 1'b0;
            pte_ppn_q              <= '0;
            pte_u_q                <= 1'b0;
            pte_rw_q               <= 1'b0;
            pte_d_q                <= 1'b0;
        end else begin
            // a flush mid-walk means the walked entry may be stale: keep it out of the TLB
            if (tlb_flush && state_q != IDLE) suppress_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    request_ready_q <= 1'b1;
                    if (request_valid && request_ready_q) begin
                        request_ready_q <= 1'b0;
                        lin_q           <= linear_address;
                        read_q          <= read_write_n;
                        user_q          <= user_mode;
                        suppress_q      <= 1'b0;
                        if (!paging_enable) begin
                            response_valid_q   <= 1'b1;
                            page_fault_q       <= 1'b0;
                            physical_address_q <= linear_address;
                            state_q            <= RESPOND;
                        end else begin
                            state_q <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    if (!fault_now && !done_now) begin
                        mem_read_valid_q   <= 1'b1;
                        mem_read_address_q <= {page_directory_base, lin_q[31:22], 2'b00};
                        state_q            <= PDE_READ;
                    end
                end
                PDE_READ: begin
                    if (mem_read_ready) begin
                        mem_read_valid_q <= 1'b0;
                        state_q          <= PDE_WAIT;
                    end
                end
                PDE_WAIT: begin
                    if (mem_read_data_valid && mem_read_data[0]) begin
                        pde_base_q <= mem_read_data[31:12];
                        pde_u_q    <= mem_read_data[2];
                        pde_rw_q   <= mem_read_data[1];
                        if (!mem_read_data[5]) begin
                            mem_write_valid_q   <= 1'b1;
                            mem_write_address_q <= mem_read_address_q;
                            mem_write_data_q    <= mem_read_data | 32'h20;
                            state_q             <= PDE_UPDATE;
                        end else begin
                            mem_read_valid_q   <= 1'b1;
                            mem_read_address_q <= {mem_read_data[31:12], lin_q[21:12], 2'b00};
                            state_q            <= PTE_READ;
                        end
                    end
                end
                PDE_UPDATE: begin
                    if (mem_write_ready) begin
                        mem_write_valid_q  <= 1'b0;
                        mem_read_valid_q   <= 1'b1;
                        mem_read_address_q <= {pde_base_q, lin_q[21:12], 2'b00};
                        state_q            <= PTE_READ;
                    end
                end
                PTE_READ: begin
                    if (mem_read_ready) begin
                        mem_read_valid_q <= 1'b0;
                        state_q          <= PTE_WAIT;
                    end
                end
                PTE_WAIT: begin
                    if (mem_read_data_valid && mem_read_data[0] && pte_perm
                        && pte_new != mem_read_data) begin
                        pte_ppn_q           <= pte_new[31:12];
                        pte_u_q             <= pte_new[2];
                        pte_rw_q            <= pte_new[1];
                        pte_d_q             <= pte_new[6];
                        mem_write_valid_q   <= 1'b1;
                        mem_write_address_q <= mem_read_address_q;
                        mem_write_data_q    <= pte_new;
                        state_q             <= PTE_UPDATE;
                    end
                end
                PTE_UPDATE: if (mem_write_ready) mem_write_valid_q <= 1'b0;
                RESPOND: begin
                    response_valid_q   <= 1'b0;
                    page_fault_q       <= 1'b0;
                    physical_address_q <= '0;
                    request_ready_q    <= 1'b1;
                    state_q            <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (fault_now) begin
                response_valid_q       <= 1'b1;
                page_fault_q           <= 1'b1;
                physical_address_q     <= '0;
                fault_error_code_q     <= {user_q, ~read_q, fault_p};
                fault_linear_address_q <= lin_q;
                state_q                <= RESPOND;
            end else if (done_now) begin
                response_valid_q   <= 1'b1;
                page_fault_q       <= 1'b0;
                physical_address_q <= done_pa;
                state_q            <= RESPOND;
            end
        end
    end

    assign request_ready        = request_ready_q;
    assign response_valid       = response_valid_q;
    assign physical_address     = physical_address_q;
    assign page_fault           = page_fault_q;
    assign fault_error_code     = fault_error_code_q;
    assign fault_linear_address = fault_linear_address_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;

endmodule

// File: tb/tb_paging_unit.sv
// Directed vector bench for paging_unit: a one-cycle-latency memory model plus a
// table of translations with hand-computed latency, address and fault results.
module tb_paging_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        paging_enable;
    logic [19:0] page_directory_base;
    logic        tlb_flush;
    logic        request_valid, request_ready;
    logic [31:0] linear_address;
    logic        read_write_n, user_mode;
    logic        response_valid;
    logic [31:0] physical_address;
    logic        page_fault;
    logic [2:0]  fault_error_code;
    logic [31:0] fault_linear_address;
    logic        mem_read_valid, mem_read_ready;
    logic [31:0] mem_read_address;
    logic        mem_read_data_valid;
    logic [31:0] mem_read_data;
    logic        mem_write_valid, mem_write_ready;
    logic [31:0] mem_write_address, mem_write_data;

    logic flush_tb, flush_mem;
    assign tlb_flush = flush_tb | flush_mem;

    always #5 clock = ~clock;

    paging_unit #(.TLB_ENTRIES(8)) dut (
        .clock(clock), .reset_n(reset_n), .paging_enable(paging_enable),
        .page_directory_base(page_directory_base), .tlb_flush(tlb_flush),
        .request_valid(request_valid), .request_ready(request_ready),
        .linear_address(linear_address), .read_write_n(read_write_n),
        .user_mode(user_mode), .response_valid(response_valid),
        .physical_address(physical_address), .page_fault(page_fault),
        .fault_error_code(fault_error_code), .fault_linear_address(fault_linear_address),
        .mem_read_valid(mem_read_valid), .mem_read_ready(mem_read_ready),
        .mem_read_address(mem_read_address), .mem_read_data_valid(mem_read_data_valid),
        .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid),
        .mem_write_ready(mem_write_ready), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          flush_req = 0;
    int          flush_done = 0;
    logic [31:0] last_wdata = '0;

    // Memory model: data returns the cycle after the read handshake; optionally
    // pulses tlb_flush alongside a PTE return so the DUT sees it in PTE_WAIT.
    initial begin
        logic [31:0] mem [logic [31:0]];
        logic        pend;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_addr = '0;
        mem_read_data_valid = 1'b0;
        mem_read_data = '0;
        flush_mem = 1'b0;
        mem[32'h10004] = 32'h0002_0027;
        mem[32'h10008] = 32'h0002_0000;
        mem[32'h1000C] = 32'h0003_0007;
        mem[32'h20008] = 32'h0ABC_D067;
        mem[32'h2000C] = 32'h0ABC_E007;
        mem[32'h20010] = 32'h0ABC_F003;
        mem[32'h20014] = 32'h0AB0_0021;
        mem[32'h2001C] = 32'h0007_7027;
        mem[32'h20020] = 32'h0008_8067;
        mem[32'h20024] = 32'h0009_9067;
        mem[32'h20028] = 32'h000A_A067;
        mem[32'h2002C] = 32'h000B_B067;
        mem[32'h30000] = 32'h0005_5067;
        forever begin
            @(negedge clock);
            mem_read_data_valid = 1'b0;
            flush_mem = 1'b0;
            if (pend) begin
                mem_read_data_valid = 1'b1;
                mem_read_data = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                if (flush_req != flush_done && pend_addr >= 32'h20000) begin
                    flush_mem = 1'b1;
                    flush_done++;
                end
                pend = 1'b0;
            end
            if (mem_read_valid && mem_read_ready) begin
                pend = 1'b1;
                pend_addr = mem_read_address;
                rd_cnt++;
            end
            if (mem_write_valid && mem_write_ready) begin
                mem[mem_write_address] = mem_write_data;
                last_wdata = mem_write_data;
                wr_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xact(input logic pe, input logic [31:0] lin, input logic rd, input logic um,
                        input logic fl_acc, output int lat, output logic [31:0] pa,
                        output logic pf, output logic [2:0] ec, output logic [31:0] cr2,
                        output logic rv_after);
        int n;
        n = 0;
        @(negedge clock);
        while (!request_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        paging_enable  = pe;
        linear_address = lin;
        read_write_n   = rd;
        user_mode      = um;
        request_valid  = 1'b1;
        flush_tb       = fl_acc;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        flush_tb      = 1'b0;
        lat = 1;
        while (!response_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        pa  = physical_address;
        pf  = page_fault;
        ec  = fault_error_code;
        cr2 = fault_linear_address;
        @(posedge clock);
        #1;
        rv_after = response_valid;
    endtask

    typedef struct {
        logic        pe;
        logic [31:0] lin;
        logic        rd;
        logic        um;
        logic        fl;
        int          lat;
        logic [31:0] pa;
        logic        pf;
        logic [2:0]  ec;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
        logic [31:0] cr2;
    } vec_t;

    initial begin
        vec_t        vq [$];
        int          lat, r0, w0;
        logic [31:0] pa, cr2;
        logic        pf, rv_after;
        logic [2:0]  ec;
        string       tag;

        reset_n = 1'b0;
        paging_enable = 1'b0;
        page_directory_base = 20'h00010;
        flush_tb = 1'b0;
        request_valid = 1'b0;
        linear_address = '0;
        read_write_n = 1'b1;
        user_mode = 1'b0;
        mem_read_ready = 1'b1;
        mem_write_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset request_ready", 32'(request_ready), 0);
        chk("reset response_valid", 32'(response_valid), 0);
        chk("reset mem_read_valid", 32'(mem_read_valid), 0);
        chk("reset mem_write_valid", 32'(mem_write_valid), 0);
        chk("reset cr2", fault_linear_address, 0);
        @(negedge clock);
        reset_n = 1'b1;

        //           pe    lin            rd    um    fl   lat pa             pf    ec      rd wr wdata          cr2
        vq.push_back('{1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1, 32'h1234_5678, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0});
        vq.push_back('{1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, 6, 32'h0ABC_D123, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0});
        vq.push_back('{1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, 2, 32'h0ABC_D123, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0});
        vq.push_back('{1'b1, 32'h0040_3456, 1'b0, 1'b1, 1'b0, 7, 32'h0ABC_E456, 1'b0, 3'b000, 2, 1, 32'h0ABC_E067, 32'h0});
        vq.push_back('{1'b1, 32'h0040_3789, 1'b0, 1'b1, 1'b0, 2, 32'h0ABC_E789, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0});
        vq.push_back('{1'b1, 32'h0080_2000, 1'b1, 1'b1, 1'b0, 4, 32'h0,         1'b1, 3'b100, 1, 0, 32'h0,         32'h0080_2000});
        vq.push_back('{1'b1, 32'h0040_4010, 1'b1, 1'b1, 1'b0, 6, 32'h0,         1'b1, 3'b101, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_5ABC, 1'b0, 1'b0, 1'b0, 7, 32'h0AB0_0ABC, 1'b0, 3'b000, 2, 1, 32'h0AB0_0061, 32'h0040_4010});
        vq.push_back('{1'b1, 32'h00C0_0ABC, 1'b1, 1'b1, 1'b0, 7, 32'h0005_5ABC, 1'b0, 3'b000, 2, 1, 32'h0003_0027, 32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_2FFF, 1'b0, 1'b1, 1'b0, 2, 32'h0ABC_DFFF, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_4010, 1'b1, 1'b0, 1'b0, 7, 32'h0ABC_F010, 1'b0, 3'b000, 2, 1, 32'h0ABC_F023, 32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_7000, 1'b1, 1'b1, 1'b0, 6, 32'h0007_7000, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_7004, 1'b0, 1'b1, 1'b0, 7, 32'h0007_7004, 1'b0, 3'b000, 2, 1, 32'h0007_7067, 32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_7008, 1'b0, 1'b1, 1'b0, 2, 32'h0007_7008, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_8000, 1'b1, 1'b1, 1'b0, 6, 32'h0008_8000, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_9000, 1'b1, 1'b1, 1'b0, 6, 32'h0009_9000, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_A000, 1'b1, 1'b1, 1'b0, 6, 32'h000A_A000, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, 6, 32'h0ABC_D123, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_5010, 1'b1, 1'b0, 1'b0, 2, 32'h0AB0_0010, 1'b0, 3'b000, 0, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_3000, 1'b1, 1'b1, 1'b0, 6, 32'h0ABC_E000, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_B004, 1'b1, 1'b1, 1'b1, 6, 32'h000B_B004, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_B004, 1'b1, 1'b1, 1'b0, 6, 32'h000B_B004, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});
        vq.push_back('{1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, 6, 32'h0ABC_D123, 1'b0, 3'b000, 2, 0, 32'h0,         32'h0040_4010});

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].fl) flush_req++;
            r0 = rd_cnt;
            w0 = wr_cnt;
            xact(vq[i].pe, vq[i].lin, vq[i].rd, vq[i].um, 1'b0, lat, pa, pf, ec, cr2, rv_after);
            tag = $sformatf("vec%0d", i);
            chk({tag, " latency"}, 32'(lat), 32'(vq[i].lat));
            chk({tag, " physical"}, pa, vq[i].pa);
            chk({tag, " page_fault"}, 32'(pf), 32'(vq[i].pf));
            if (vq[i].pf) chk({tag, " error_code"}, 32'(ec), 32'(vq[i].ec));
            chk({tag, " mem reads"}, 32'(rd_cnt - r0), 32'(vq[i].nrd));
            chk({tag, " mem writes"}, 32'(wr_cnt - w0), 32'(vq[i].nwr));
            if (vq[i].nwr > 0) chk({tag, " write data"}, last_wdata, vq[i].wd);
            chk({tag, " cr2"}, cr2, vq[i].cr2);
            chk({tag, " one-cycle pulse"}, 32'(rv_after), 0);
        end

        // flush coincident with accept: the cached page must miss, then refill
        xact(1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b1, lat, pa, pf, ec, cr2, rv_after);
        chk("flush at accept latency", 32'(lat), 6);
        chk("flush at accept physical", pa, 32'h0ABC_D123);
        xact(1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, lat, pa, pf, ec, cr2, rv_after);
        chk("refilled hit latency", 32'(lat), 2);

        // reset while the walker holds a stalled PDE read
        mem_read_ready = 1'b0;
        @(negedge clock);
        for (int n = 0; n < 50 && !request_ready; n++) @(negedge clock);
        linear_address = 32'h0040_8000;
        read_write_n = 1'b1;
        user_mode = 1'b1;
        request_valid = 1'b1;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("stalled read valid held", 32'(mem_read_valid), 1);
        chk("stalled read address", mem_read_address, 32'h0001_0004);
        reset_n = 1'b0;
        #1;
        chk("mid-walk reset read valid", 32'(mem_read_valid), 0);
        chk("mid-walk reset ready", 32'(request_ready), 0);
        chk("mid-walk reset cr2", fault_linear_address, 0);
        mem_read_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        r0 = rd_cnt;
        xact(1'b1, 32'h0040_2123, 1'b1, 1'b1, 1'b0, lat, pa, pf, ec, cr2, rv_after);
        chk("post-reset rewalk latency", 32'(lat), 6);
        chk("post-reset rewalk reads", 32'(rd_cnt - r0), 2);
        chk("post-reset physical", pa, 32'h0ABC_D123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
